// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the in-order pipeline controller: stage indices
// and the controller FSM encoding.
package cpu_pipe_pkg;

  // Fixed stage positions; WB is always the last stage (NUM_STAGES-1).
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  // Controller operating mode.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline perf counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count up on inc, sticking at all-ones; clear wins over inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central controller for the in-order pipeline: tracks per-stage valid bits,
// arbitrates cache stalls, load-use hazards, redirects and panic, and drives
// the per-stage advance/flush enables, PC enable and perf counters.
module pipeline_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_stall_req,
  input  logic                  mem_stall_req,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_panic,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  output logic                  pc_en,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int STG_WB = NUM_STAGES - 1;

  pipe_state_e           state_r;
  pipe_state_e           state_next_s;
  logic [NUM_STAGES-1:1] valid_r;
  logic [NUM_STAGES-1:1] valid_next_s;
  logic [NUM_STAGES-1:0] valid_s;
  logic                  fetch_valid_s;
  logic                  src1_hit_s;
  logic                  src2_hit_s;
  logic                  load_use_s;
  logic                  redirect_s;
  logic                  panic_s;
  logic                  drained_s;
  logic                  advance_s;
  logic                  ex_bubble_s;
  logic                  stall_inc_s;
  logic                  flush_inc_s;

  // IF validity is combinational: a fetch is present whenever we run and the
  // I-cache delivers. Held low during reset so all valid bits read zero.
  assign fetch_valid_s = reset & (state_r == ST_RUN) & ~if_stall_req;
  assign valid_s       = {valid_r, fetch_valid_s};
  assign stage_valid   = valid_s;

  assign src1_hit_s = id_use_rs1 & (id_rs1 == ex_rd);
  assign src2_hit_s = id_use_rs2 & (id_rs2 == ex_rd);
  assign load_use_s = valid_r[STG_EX] & ex_is_load & (ex_rd != '0)
                    & (src1_hit_s | src2_hit_s) & valid_r[STG_ID];
  assign redirect_s = valid_r[STG_EX] & ex_redirect;
  assign panic_s    = valid_r[STG_ID] & id_panic & (state_r == ST_RUN);
  assign drained_s  = (valid_r[NUM_STAGES-2:1] == '0);
  assign halted     = (state_r == ST_HALTED);

  // Event priority, stage enables/flushes, next valid bits and next state.
  always_comb begin
    pc_en        = 1'b0;
    stage_en     = '1;
    stage_flush  = '0;
    valid_next_s = valid_r;
    state_next_s = state_r;
    advance_s    = 1'b0;
    ex_bubble_s  = 1'b0;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    case (state_r)
      ST_RUN, ST_DRAIN: begin
        if (mem_stall_req) begin
          stage_en[NUM_STAGES-2:0] = '0;
        end else if (redirect_s) begin
          stage_flush[STG_IF] = 1'b1;
          stage_flush[STG_ID] = 1'b1;
          pc_en               = 1'b1;
          flush_inc_s         = 1'b1;
          advance_s           = 1'b1;
        end else if (load_use_s) begin
          stage_en[STG_IF]    = 1'b0;
          stage_en[STG_ID]    = 1'b0;
          stage_flush[STG_EX] = 1'b1;
          ex_bubble_s         = 1'b1;
        end else if (panic_s) begin
          stage_flush[STG_IF] = 1'b1;
          state_next_s        = ST_DRAIN;
          advance_s           = 1'b1;
        end else if (if_stall_req) begin
          stage_flush[STG_IF] = 1'b1;
          advance_s           = 1'b1;
        end else begin
          pc_en     = 1'b1;
          advance_s = 1'b1;
        end

        // While draining nothing new is fetched; only the older stages move.
        if (state_r == ST_DRAIN) begin
          pc_en = 1'b0;
          if (!mem_stall_req) begin
            stage_flush[STG_IF] = 1'b1;
          end else begin
            stage_flush[STG_IF] = 1'b0;
          end
          if (drained_s) begin
            state_next_s = ST_HALTED;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end else begin
          stall_inc_s = ~pc_en;
        end

        // Valid shift; a load-use bubble enters at the ID->EX boundary while
        // the load and everything older keep moving.
        if (advance_s) begin
          for (int i = 1; i < NUM_STAGES; i++) begin
            valid_next_s[i] = valid_s[i-1] & ~stage_flush[i-1];
          end
        end else if (ex_bubble_s) begin
          valid_next_s[STG_EX] = 1'b0;
          for (int i = STG_EX + 1; i < NUM_STAGES; i++) begin
            valid_next_s[i] = valid_s[i-1];
          end
        end else begin
          valid_next_s[STG_WB] = 1'b0;
        end
      end
      ST_HALTED: begin
        stage_en     = '0;
        state_next_s = ST_HALTED;
      end
      default: begin
        stage_en     = '0;
        state_next_s = ST_HALTED;
      end
    endcase
  end

  // Controller state and per-stage valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      valid_r <= '0;
    end else begin
      state_r <= state_next_s;
      valid_r <= valid_next_s;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (stall_inc_s),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (flush_inc_s),
    .count (flush_count)
  );

endmodule
